// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding, default operand width and radix-4 Booth select codes
package mult_pkg;
    localparam int DEFAULT_WIDTH = 32;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam logic [2:0] SEL_ZERO = 3'b000;
    localparam logic [2:0] SEL_P1   = 3'b001;
    localparam logic [2:0] SEL_P2   = 3'b011;
    localparam logic [2:0] SEL_M2   = 3'b100;
    localparam logic [2:0] SEL_M1   = 3'b110;
endpackage

// File: rtl/mult_booth_encoder.sv
// mult_booth_encoder: streams the radix-4 Booth windows of a multiplier, one per accepted handshake
module mult_booth_encoder
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int SW = $clog2(WIDTH / 2)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplier,
    output logic             ready,
    output logic [2:0]       select,
    output logic             sel_valid,
    input  logic             sel_ready,
    output logic [SW-1:0]    step,
    output logic             last,
    output logic             done
);
    localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH / 2 - 1);
    state_t         state, state_nxt;
    logic [WIDTH:0] shreg;
    logic           xfer;
    assign ready     = state == IDLE;
    assign sel_valid = state == RUN;
    assign done      = state == DONE;
    assign last      = sel_valid && step == LAST_STEP;
    assign xfer      = sel_valid && sel_ready;
    // shreg is cleared on the final transfer, so the window bits read SEL_ZERO outside RUN
    assign select    = shreg[2:0];
    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end
    // next-state: IDLE -start-> RUN -last transfer-> DONE -> IDLE
    always_comb begin
        state_nxt = state;
        if (state == IDLE && start)        state_nxt = RUN;
        else if (state == RUN && xfer && last) state_nxt = DONE;
        else if (state == DONE)            state_nxt = IDLE;
    end
    // window shifter: load {multiplier, 0}, shift right two with sign fill per transfer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            step  <= '0;
        end else if (ready && start) begin
            shreg <= {multiplier, 1'b0};
            step  <= '0;
        end else if (xfer) begin
            shreg <= last ? '0 : {{2{shreg[WIDTH]}}, shreg[WIDTH:2]};
            step  <= step + SW'(1);
        end
    end
endmodule

// File: doc/mult_booth_encoder.md
MULT_BOOTH_ENCODER -- requirements
Module: mult_booth_encoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the multiplier operand width; it must be even and at least 4.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin encoding `multiplier`.
REQ-005 The block SHALL have port multiplier, input, WIDTH bits: two's-complement operand, sampled on an accepted start.
REQ-006 The block SHALL have port ready, output, 1 bit: high only in IDLE, meaning start is accepted this cycle.
REQ-007 The block SHALL have port select, output, 3 bits: current radix-4 Booth window {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
REQ-008 The block SHALL have port sel_valid, output, 1 bit: select holds a valid window.
REQ-009 The block SHALL have port sel_ready, input, 1 bit: the consumer accepts select this cycle.
REQ-010 The block SHALL have port step, output, clog2(WIDTH/2) bits: index i of the current window.
REQ-011 The block SHALL have port last, output, 1 bit: high with sel_valid when i = WIDTH/2-1.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last window is accepted.

Function
REQ-013 The block SHALL implement states IDLE, RUN and DONE.
REQ-014 The block SHALL, in IDLE with start=1, load the (WIDTH+1)-bit shift register with {multiplier, 1'b0}, clear step and enter RUN on the next edge.
REQ-015 The block SHALL hold sel_valid=1 in RUN, with select = shreg[2:0] driven directly from registers (zero combinational latency).
REQ-016 The block SHALL treat sel_valid & sel_ready as a transfer; on a transfer the shift register shifts right by 2 with sign fill and step increments.
REQ-017 The block SHALL, on a transfer while last=1, enter DONE; DONE asserts done for exactly one cycle, then returns to IDLE.
REQ-018 The block SHALL hold select, step and last stable while sel_valid=1 and sel_ready=0, for any stall length.
REQ-019 The block SHALL drive select=3'b000 and sel_valid=0 outside RUN.
REQ-020 The block SHALL ignore start outside IDLE; the shift register is not reloaded.
REQ-021 The block SHALL produce exactly WIDTH/2 transfers per operation, with no bubbles when sel_ready is held high (one window per cycle).
REQ-022 The block SHALL satisfy the arithmetic rule: the sum over i of weight(select_i)·4^i, with weight 000/111=0, 001/010=+1, 011=+2, 100=-2, 101/110=-1, equals the signed multiplier.

Reset
REQ-023 The block SHALL, on reset=1 at any time including mid-operation, asynchronously force state=IDLE, shreg=0, step=0, select=000, sel_valid=0, last=0 and done=0, with ready=1.
REQ-024 The block SHALL accept start on the first clock edge after reset deasserts.

Structure
REQ-025 The design SHALL use a shared package mult_pkg holding the state encoding, the default WIDTH, and the select-code constants (SEL_ZERO, SEL_P1, SEL_P2, SEL_M2, SEL_M1).
REQ-026 The design SHALL be a single module with no sub-module required; the bench checks select by feeding it to the existing decoder_mult and confirming exactly one of its outputs is high.

Verification
REQ-027 The bench SHALL check: multiplier=0x00000003, sel_ready=1 -> select 110, 001, then 000 x14; last at step 15; done one cycle later.
REQ-028 The bench SHALL check: multiplier=0xFFFFFFFF -> select 110, then 111 x15; sum of weights = -1.
REQ-029 The bench SHALL check: multiplier=0x80000000 -> select 000 x15, then 100 at step 15; sum of weights = -2^31.
REQ-030 The bench SHALL check: sel_ready held low 5 cycles at step 3 -> select, step and sel_valid unchanged; the sequence resumes intact.
REQ-031 The bench SHALL check: reset pulsed at step 7 -> immediately ready=1, sel_valid=0, select=000, step=0; a new start then encodes correctly.
REQ-032 The bench SHALL check: start with multiplier=0x12345678 pulsed during RUN -> ignored; the original operand's windows complete unchanged.
